bp_cache_dma_rr_arbiter: RTL and testbench
==========================================

// Module: bp_cache_dma_rr_arbiter
// PURPOSE
//  Shares one DRAM cache-DMA channel among num_dma_p L2 bank DMA ports.
//  Sits between the per-bank dma_pkt/dma_data interfaces of the tethered
//  testbench and a single DRAM model port.
//  Round-robin packet arbitration; write bursts lock the channel; read fills are routed back in order.
// PARAMETERS
//  num_dma_p         4   number of requesting bank DMA ports (>=2)
//  dma_addr_width_p  28  DMA address width
//  dma_data_width_p  64  DMA beat width (l2_fill_width_p)
//  dma_burst_len_p   8   beats per packet (l2_block_size_in_fill_p, >=1)
//  rd_tag_els_p      4   max outstanding read packets
//  dma_pkt_width_lp = `bsg_cache_dma_pkt_width(dma_addr_width_p); packet = {write_not_read, addr}
// PORTS
//  clk_i                 in   1                         clock
//  reset_i               in   1                         async reset, active-high
//  req_pkt_i             in   num_dma_p*dma_pkt_width_lp  per-requester packet
//  req_pkt_v_i           in   num_dma_p                 packet valid
//  req_pkt_ready_and_o   out  num_dma_p                 packet accepted
//  req_data_i            in   num_dma_p*dma_data_width_p  write beats from requesters
//  req_data_v_i          in   num_dma_p                 write beat valid
//  req_data_ready_and_o  out  num_dma_p                 write beat accepted
//  req_data_o            out  num_dma_p*dma_data_width_p  read beats to requesters (broadcast)
//  req_data_v_o          out  num_dma_p                 read beat valid (one-hot)
//  req_data_ready_and_i  in   num_dma_p                 requester takes read beat
//  dma_pkt_o             out  dma_pkt_width_lp          packet to DRAM
//  dma_pkt_v_o           out  1                         packet valid
//  dma_pkt_ready_and_i   in   1                         DRAM accepts packet
//  dma_data_o            out  dma_data_width_p          write beat to DRAM
//  dma_data_v_o          out  1                         write beat valid
//  dma_data_ready_and_i  in   1                         DRAM accepts write beat
//  dma_data_i            in   dma_data_width_p          read beat from DRAM
//  dma_data_v_i          in   1                         read beat valid
//  dma_data_ready_and_o  out  1                         read beat accepted
// BEHAVIOUR
//  Reset (async, reset_i=1): state=IDLE, rr_ptr=0, wr_cnt=0, rd_cnt=0, tag FIFO empty; all _v_o and _ready_and_o = 0.
//  Reset mid-burst discards locked write and all outstanding read tags; no recovery.
//  FSM IDLE / WRITE:
//   IDLE: eligible[i] = req_pkt_v_i[i] & (write_not_read[i] | ~tag_full).
//    Grant g = first eligible at/after rr_ptr (wraps num_dma_p-1 -> 0); combinational forward:
//    dma_pkt_o=req_pkt_i[g], dma_pkt_v_o=|eligible, req_pkt_ready_and_o[g]=dma_pkt_ready_and_i.
//    On handshake: rr_ptr <= (g+1) mod num_dma_p. Write -> WRITE, wr_id<=g, wr_cnt<=0. Read -> push g to tag FIFO, stay IDLE.
//    No handshake: rr_ptr unchanged; grant may change next cycle (no hold).
//   WRITE: no packets granted (dma_pkt_v_o=0). dma_data_o=req_data_i[wr_id], dma_data_v_o=req_data_v_i[wr_id],
//    req_data_ready_and_o[wr_id]=dma_data_ready_and_i; others 0. Each beat handshake wr_cnt++;
//    beat dma_burst_len_p-1 -> IDLE same edge. Packet may be granted the following cycle.
//  Read return (independent of FSM, runs concurrently with WRITE):
//   tag FIFO in order, rd_tag_els_p deep, tag_full registered; no push when full even with same-cycle pop.
//   FIFO empty: dma_data_ready_and_o=0, req_data_v_o=0 (stray DRAM beats stall, never dropped).
//   Non-empty, head h: req_data_o=dma_data_i to all, req_data_v_o=onehot(h)&dma_data_v_i,
//    dma_data_ready_and_o=req_data_ready_and_i[h]. Handshake rd_cnt++; last beat pops head, rd_cnt<=0.
//   Same-cycle push and pop legal when not full; count unchanged.
//  Zero-latency combinational paths pkt/data; no registers on data. Widths: counters $clog2(dma_burst_len_p+1).
//  req_data_ready_and_o[i]=0 whenever i!=wr_id or state=IDLE.
// TESTING
//  1 reset: hold reset_i 3 cycles, all req_pkt_v_i=1 -> every _v_o and _ready_and_o 0; release -> req 0 granted first.
//  2 fairness: 4 reads continuously valid, DRAM always ready -> grant order 0,1,2,3,0; tag FIFO fills at 4, grants stop.
//  3 write lock: req1 write pkt addr 0x40 + 8 beats 0x11..0x18, req2 read valid -> req2 not granted until 8th beat accepted,
//   DRAM sees 0x11..0x18 in order, req2 granted next cycle.
//  4 read routing: reads from 3 then 0; DRAM returns 16 beats -> first 8 only req_data_v_o[3], next 8 only [0]; FIFO empty.
//  5 backpressure: req_data_ready_and_i[h]=0 for 5 cycles mid-fill -> dma_data_ready_and_o=0, rd_cnt held, no beat lost.
//  6 async reset at write beat 4 -> outputs 0 immediately (before clock edge); after release state IDLE, FIFO empty.

Source files
------------

// File: rtl/bp_cache_dma_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bp_cache_dma_rr_arbiter
// Purpose  : Shares one DRAM cache-DMA channel among num_dma_p L2 bank DMA
//            ports. Read and write packets are arbitrated round-robin. A granted
//            write locks the channel until its burst has been forwarded. Read
//            fill beats are routed back to requesters in packet order through
//            a tag FIFO.
// Ports    : clk_i / reset_i            clock, async active-high reset
//            req_pkt_*                  per-requester packet {write_not_read, addr}
//            req_data_i/_v_i/_ready_o   per-requester write beats
//            req_data_o/_v_o/_ready_i   read beats to requesters (data broadcast)
//            dma_pkt_*                  packet channel to DRAM
//            dma_data_o/_v_o/_ready_i   write beats to DRAM
//            dma_data_i/_v_i/_ready_o   read beats from DRAM
// Revision : 1.0  initial release
// ============================================================================
module bp_cache_dma_rr_arbiter #(
   parameter int num_dma_p        = 4,
   parameter int dma_addr_width_p = 28,
   parameter int dma_data_width_p = 64,
   parameter int dma_burst_len_p  = 8,
   parameter int rd_tag_els_p     = 4,
   localparam int dma_pkt_width_lp = dma_addr_width_p + 1
) (
   input  logic                                    clk_i,
   input  logic                                    reset_i,
   input  logic [num_dma_p*dma_pkt_width_lp-1:0]   req_pkt_i,
   input  logic [num_dma_p-1:0]                    req_pkt_v_i,
   output logic [num_dma_p-1:0]                    req_pkt_ready_and_o,
   input  logic [num_dma_p*dma_data_width_p-1:0]   req_data_i,
   input  logic [num_dma_p-1:0]                    req_data_v_i,
   output logic [num_dma_p-1:0]                    req_data_ready_and_o,
   output logic [num_dma_p*dma_data_width_p-1:0]   req_data_o,
   output logic [num_dma_p-1:0]                    req_data_v_o,
   input  logic [num_dma_p-1:0]                    req_data_ready_and_i,
   output logic [dma_pkt_width_lp-1:0]             dma_pkt_o,
   output logic                                    dma_pkt_v_o,
   input  logic                                    dma_pkt_ready_and_i,
   output logic [dma_data_width_p-1:0]             dma_data_o,
   output logic                                    dma_data_v_o,
   input  logic                                    dma_data_ready_and_i,
   input  logic [dma_data_width_p-1:0]             dma_data_i,
   input  logic                                    dma_data_v_i,
   output logic                                    dma_data_ready_and_o
);

   localparam int id_w_lp      = $clog2(num_dma_p);
   localparam int cnt_w_lp     = $clog2(dma_burst_len_p + 1);
   localparam int tag_ptr_w_lp = (rd_tag_els_p > 1) ? $clog2(rd_tag_els_p) : 1;
   localparam int tag_cnt_w_lp = $clog2(rd_tag_els_p + 1);
   localparam logic [cnt_w_lp-1:0]     last_beat_lp = cnt_w_lp'(dma_burst_len_p - 1);
   localparam logic [id_w_lp-1:0]      last_id_lp   = id_w_lp'(num_dma_p - 1);
   localparam logic [tag_ptr_w_lp-1:0] last_tag_lp  = tag_ptr_w_lp'(rd_tag_els_p - 1);
   localparam logic [tag_cnt_w_lp-1:0] tag_depth_lp = tag_cnt_w_lp'(rd_tag_els_p);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      WRITE = 1'b1
   } state_e;

   state_e                  state;
   logic [id_w_lp-1:0]      rr_ptr;
   logic [id_w_lp-1:0]      wr_id;
   logic [cnt_w_lp-1:0]     wr_cnt;
   logic [cnt_w_lp-1:0]     rd_cnt;

   logic [id_w_lp-1:0]      tags [rd_tag_els_p];
   logic [tag_ptr_w_lp-1:0] tag_wptr;
   logic [tag_ptr_w_lp-1:0] tag_rptr;
   logic [tag_cnt_w_lp-1:0] tag_cnt;
   logic [tag_cnt_w_lp-1:0] tag_cnt_n;
   logic                    tag_full;
   logic                    tag_empty;
   logic [id_w_lp-1:0]      head;

   logic [num_dma_p-1:0]    eligible;
   logic [id_w_lp-1:0]      grant;
   logic                    pkt_hs;
   logic                    pkt_is_wr;
   logic                    wr_hs;
   logic                    rd_active;
   logic                    rd_hs;
   logic                    tag_push;
   logic                    tag_pop;

   // Reads need a free tag slot; writes never touch the tag FIFO.
   for (genvar i = 0; i < num_dma_p; i++) begin : g_elig
      assign eligible[i] = req_pkt_v_i[i]
                         & (req_pkt_i[i*dma_pkt_width_lp + dma_pkt_width_lp - 1] | ~tag_full);
   end

   // First eligible requester at or after rr_ptr, wrapping.
   always_comb begin
      int idx;
      logic found;
      grant = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < num_dma_p; k++) begin
         idx = (int'(rr_ptr) + k) % num_dma_p;
         if (!found && eligible[idx]) begin
            found = 1'b1;
            grant = id_w_lp'(idx);
         end
      end
   end

   // Everything handshake-visible is masked by reset so outputs drop at once.
   assign dma_pkt_o   = req_pkt_i[grant*dma_pkt_width_lp +: dma_pkt_width_lp];
   assign dma_pkt_v_o = ~reset_i & (state == IDLE) & (|eligible);
   assign pkt_hs      = dma_pkt_v_o & dma_pkt_ready_and_i;
   assign pkt_is_wr   = dma_pkt_o[dma_pkt_width_lp-1];

   assign dma_data_o   = req_data_i[wr_id*dma_data_width_p +: dma_data_width_p];
   assign dma_data_v_o = ~reset_i & (state == WRITE) & req_data_v_i[wr_id];
   assign wr_hs        = dma_data_v_o & dma_data_ready_and_i;

   always_comb begin
      req_pkt_ready_and_o  = '0;
      req_data_ready_and_o = '0;
      if (dma_pkt_v_o)
         req_pkt_ready_and_o[grant] = dma_pkt_ready_and_i;
      if (!reset_i && state == WRITE)
         req_data_ready_and_o[wr_id] = dma_data_ready_and_i;
   end

   // Packet / write-burst FSM.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state  <= IDLE;
         rr_ptr <= '0;
         wr_id  <= '0;
         wr_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pkt_hs) begin
                  rr_ptr <= (grant == last_id_lp) ? '0 : grant + 1'b1;
                  if (pkt_is_wr) begin
                     state  <= WRITE;
                     wr_id  <= grant;
                     wr_cnt <= '0;
                  end
               end
            end
            WRITE: begin
               if (wr_hs) begin
                  if (wr_cnt == last_beat_lp) begin
                     state  <= IDLE;
                     wr_cnt <= '0;
                  end else begin
                     wr_cnt <= wr_cnt + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Read return: the FIFO head names the requester owning the current fill.
   assign tag_empty = (tag_cnt == '0);
   assign head      = tags[tag_rptr];
   assign rd_active = ~reset_i & ~tag_empty;

   assign req_data_o           = {num_dma_p{dma_data_i}};
   assign dma_data_ready_and_o = rd_active & req_data_ready_and_i[head];
   assign rd_hs                = dma_data_v_i & dma_data_ready_and_o;
   assign tag_pop              = rd_hs & (rd_cnt == last_beat_lp);
   // eligible already excludes reads while full, so a granted read always fits.
   assign tag_push             = pkt_hs & ~pkt_is_wr;

   always_comb begin
      req_data_v_o = '0;
      if (rd_active && dma_data_v_i)
         req_data_v_o[head] = 1'b1;
   end

   always_comb begin
      tag_cnt_n = tag_cnt + tag_cnt_w_lp'(tag_push) - tag_cnt_w_lp'(tag_pop);
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         tag_wptr <= '0;
         tag_rptr <= '0;
         tag_cnt  <= '0;
         tag_full <= 1'b0;
         rd_cnt   <= '0;
      end else begin
         if (tag_push)
            tag_wptr <= (tag_wptr == last_tag_lp) ? '0 : tag_wptr + 1'b1;
         if (tag_pop)
            tag_rptr <= (tag_rptr == last_tag_lp) ? '0 : tag_rptr + 1'b1;
         tag_cnt  <= tag_cnt_n;
         tag_full <= (tag_cnt_n == tag_depth_lp);
         if (rd_hs)
            rd_cnt <= (rd_cnt == last_beat_lp) ? '0 : rd_cnt + 1'b1;
      end
   end

   // Tag storage needs no reset: only entries below tag_cnt are ever read.
   always_ff @(posedge clk_i) begin
      if (tag_push)
         tags[tag_wptr] <= grant;
   end

endmodule
`default_nettype wire

// File: tb/tb_bp_cache_dma_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_cache_dma_rr_arbiter
// Purpose  : Directed bench for bp_cache_dma_rr_arbiter. Stimulus threads push
//            expected packets, write beats and read-return beats into queues;
//            a monitor pops and compares on every DUT-side handshake.
// Revision : 1.0  initial release
// ============================================================================
module tb_bp_cache_dma_rr_arbiter;

   localparam int N  = 4;
   localparam int AW = 28;
   localparam int W  = AW + 1;
   localparam int DW = 64;
   localparam int BL = 8;

   logic              clk;
   logic              reset;
   logic [N*W-1:0]    req_pkt_i;
   logic [N-1:0]      pkt_v;
   logic [N-1:0]      req_pkt_ready_and_o;
   logic [N*DW-1:0]   req_data_i;
   logic [N-1:0]      data_v;
   logic [N-1:0]      req_data_ready_and_o;
   logic [N*DW-1:0]   req_data_o;
   logic [N-1:0]      req_data_v_o;
   logic [N-1:0]      rd_rdy;
   logic [W-1:0]      dma_pkt_o;
   logic              dma_pkt_v_o;
   logic              dma_pkt_rdy;
   logic [DW-1:0]     dma_data_o;
   logic              dma_data_v_o;
   logic              dma_data_rdy;
   logic [DW-1:0]     dma_data_i;
   logic              dma_data_v_i;
   logic              dma_data_ready_and_o;

   logic [W-1:0]      pkt   [N];
   logic [DW-1:0]     wdata [N];

   int errors = 0;
   int checks = 0;

   logic [W-1:0]  pkt_q[$];
   logic [DW-1:0] wr_q[$];
   logic [DW-1:0] rd_dat_q[$];
   int            rd_id_q[$];

   always_comb begin
      for (int i = 0; i < N; i++) begin
         req_pkt_i[i*W +: W]    = pkt[i];
         req_data_i[i*DW +: DW] = wdata[i];
      end
   end

   bp_cache_dma_rr_arbiter #(
      .num_dma_p(N), .dma_addr_width_p(AW), .dma_data_width_p(DW),
      .dma_burst_len_p(BL), .rd_tag_els_p(4)
   ) dut (
      .clk_i(clk), .reset_i(reset),
      .req_pkt_i(req_pkt_i), .req_pkt_v_i(pkt_v), .req_pkt_ready_and_o(req_pkt_ready_and_o),
      .req_data_i(req_data_i), .req_data_v_i(data_v), .req_data_ready_and_o(req_data_ready_and_o),
      .req_data_o(req_data_o), .req_data_v_o(req_data_v_o), .req_data_ready_and_i(rd_rdy),
      .dma_pkt_o(dma_pkt_o), .dma_pkt_v_o(dma_pkt_v_o), .dma_pkt_ready_and_i(dma_pkt_rdy),
      .dma_data_o(dma_data_o), .dma_data_v_o(dma_data_v_o), .dma_data_ready_and_i(dma_data_rdy),
      .dma_data_i(dma_data_i), .dma_data_v_i(dma_data_v_i), .dma_data_ready_and_o(dma_data_ready_and_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, want, $time);
      end
   endtask

   task automatic fail_event(input string nm);
      checks++;
      errors++;
      $display("FAIL %s: got event, expected none (or timeout) at %0t", nm, $time);
   endtask

   function automatic logic [W-1:0] mk_pkt(input logic wr, input logic [AW-1:0] addr);
      return {wr, addr};
   endfunction

   function automatic logic [63:0] all_outs();
      return 64'({dma_pkt_v_o, req_pkt_ready_and_o, req_data_ready_and_o,
                  req_data_v_o, dma_data_v_o, dma_data_ready_and_o});
   endfunction

   // ---------------- scoreboard monitor ----------------
   initial begin
      int id;
      logic [DW-1:0] d;
      logic [W-1:0]  p;
      forever begin
         @(negedge clk);
         if (dma_pkt_v_o && dma_pkt_rdy) begin
            if (pkt_q.size() == 0) fail_event("pkt_unexpected");
            else begin
               p = pkt_q.pop_front();
               chk("pkt_order", 64'(dma_pkt_o), 64'(p));
            end
         end
         if (dma_data_v_o && dma_data_rdy) begin
            if (wr_q.size() == 0) fail_event("wr_unexpected");
            else begin
               d = wr_q.pop_front();
               chk("wr_beat", dma_data_o, d);
            end
         end
         if ((req_data_v_o & rd_rdy) != '0) begin
            if (rd_id_q.size() == 0) fail_event("rd_unexpected");
            else begin
               id = rd_id_q.pop_front();
               d  = rd_dat_q.pop_front();
               chk("rd_route", 64'(req_data_v_o), 64'(1) << id);
               chk("rd_data", req_data_o[id*DW +: DW], d);
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_pkt_grant(input int id);
      bit ok = 0;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (req_pkt_ready_and_o[id]) begin ok = 1; break; end
      end
      if (!ok) fail_event("grant_timeout");
      @(posedge clk); #1;
      pkt_v[id] = 1'b0;
   endtask

   task automatic wr_burst(input int id, input logic [DW-1:0] base, input int nb);
      for (int b = 0; b < nb; b++) begin
         bit ok = 0;
         wdata[id]  = base + DW'(b);
         data_v[id] = 1'b1;
         wr_q.push_back(base + DW'(b));
         for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            chk("lock_nopkt", 64'(dma_pkt_v_o), 64'd0);
            if (req_data_ready_and_o[id]) begin ok = 1; break; end
         end
         if (!ok) fail_event("wr_timeout");
         @(posedge clk); #1;
      end
      data_v[id] = 1'b0;
   endtask

   task automatic dram_fill(input int id, input logic [DW-1:0] base, input int stall_at);
      for (int b = 0; b < BL; b++) begin
         bit ok = 0;
         dma_data_i   = base + DW'(b);
         dma_data_v_i = 1'b1;
         rd_id_q.push_back(id);
         rd_dat_q.push_back(base + DW'(b));
         if (b == stall_at) begin
            rd_rdy[id] = 1'b0;
            repeat (5) begin
               @(negedge clk);
               chk("bp_stall", 64'(dma_data_ready_and_o), 64'd0);
            end
            @(posedge clk); #1;
            rd_rdy[id] = 1'b1;
         end
         for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (dma_data_ready_and_o) begin ok = 1; break; end
         end
         if (!ok) fail_event("rd_timeout");
         @(posedge clk); #1;
      end
      dma_data_v_i = 1'b0;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [N-1:0] r;
      reset        = 1'b1;
      dma_pkt_rdy  = 1'b1;
      dma_data_rdy = 1'b1;
      dma_data_i   = '0;
      dma_data_v_i = 1'b0;
      rd_rdy       = '1;
      data_v       = '0;
      for (int i = 0; i < N; i++) begin
         pkt[i]   = mk_pkt(1'b0, AW'(28'h100 * (i + 1)));
         wdata[i] = '0;
      end
      pkt_v = '1;

      // 1: reset holds every valid/ready low, then req 0 wins first.
      for (int i = 0; i < N; i++) pkt_q.push_back(pkt[i]);
      repeat (3) begin
         @(negedge clk);
         chk("reset_outs", all_outs(), 64'd0);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("first_grant", 64'(req_pkt_ready_and_o), 64'h1);

      // 2: grants 0,1,2,3, then tag FIFO full blocks further reads.
      repeat (4) @(posedge clk);
      repeat (4) begin
         @(negedge clk);
         chk("full_stall", 64'(dma_pkt_v_o), 64'd0);
      end
      @(posedge clk); #1;
      pkt_v = 4'b0001;
      pkt_q.push_back(pkt[0]);
      fork
         begin
            dram_fill(0, 64'hA000, -1);
            dram_fill(1, 64'hB000, -1);
            dram_fill(2, 64'hC000, -1);
            dram_fill(3, 64'hD000, -1);
            dram_fill(0, 64'hE000, -1);
         end
         wait_pkt_grant(0);
      join

      // 3: write from req1 locks channel; req2 read waits for the 8th beat.
      pkt[1] = mk_pkt(1'b1, 28'h40);
      pkt[2] = mk_pkt(1'b0, 28'h300);
      pkt_v  = 4'b0110;
      pkt_q.push_back(pkt[1]);
      pkt_q.push_back(pkt[2]);
      @(negedge clk);
      chk("wr_grant", 64'(req_pkt_ready_and_o), 64'h2);
      @(posedge clk); #1;
      pkt_v[1] = 1'b0;
      wr_burst(1, 64'h11, BL);
      @(negedge clk);
      chk("post_lock_grant", 64'(req_pkt_ready_and_o), 64'h4);
      @(posedge clk); #1;
      pkt_v[2] = 1'b0;
      dram_fill(2, 64'h2200, -1);

      // 4/5: reads from 3 then 0, second fill stalled by requester 0.
      pkt[3] = mk_pkt(1'b0, 28'h400);
      pkt[0] = mk_pkt(1'b0, 28'h100);
      pkt_v  = 4'b1001;
      pkt_q.push_back(pkt[3]);
      pkt_q.push_back(pkt[0]);
      for (int t = 0; t < 20 && pkt_v != '0; t++) begin
         @(negedge clk);
         r = req_pkt_ready_and_o;
         @(posedge clk); #1;
         pkt_v = pkt_v & ~r;
      end
      chk("reads_issued", 64'(pkt_v), 64'd0);
      dram_fill(3, 64'h3300, -1);
      dram_fill(0, 64'h0300, 3);
      dma_data_v_i = 1'b1;
      @(negedge clk);
      chk("empty_stall", 64'(dma_data_ready_and_o), 64'd0);
      chk("empty_nov", 64'(req_data_v_o), 64'd0);
      @(posedge clk); #1;
      dma_data_v_i = 1'b0;

      // 6: async reset in the middle of a write burst.
      pkt[0] = mk_pkt(1'b1, 28'h80);
      pkt_v  = 4'b0001;
      pkt_q.push_back(pkt[0]);
      wait_pkt_grant(0);
      wr_burst(0, 64'h51, 4);
      wdata[0]  = 64'h55;
      data_v[0] = 1'b1;
      #1;
      chk("pre_reset_wv", 64'(dma_data_v_o), 64'd1);
      pkt_v        = 4'b1000;
      dma_data_v_i = 1'b1;
      reset        = 1'b1;
      #1;
      chk("async_reset_outs", all_outs(), 64'd0);
      pkt_q.push_back(pkt[3]);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("post_reset_idle_wv", 64'(dma_data_v_o), 64'd0);
      chk("post_reset_wr_rdy", 64'(req_data_ready_and_o), 64'd0);
      chk("post_reset_fifo_empty", 64'(dma_data_ready_and_o), 64'd0);
      chk("post_reset_grant", 64'(req_pkt_ready_and_o), 64'h8);
      @(posedge clk); #1;
      pkt_v        = '0;
      data_v       = '0;
      dma_data_v_i = 1'b0;
      dram_fill(3, 64'h6600, -1);

      repeat (3) @(posedge clk);
      chk("pkt_q_drained", 64'(pkt_q.size()), 64'd0);
      chk("wr_q_drained", 64'(wr_q.size()), 64'd0);
      chk("rd_q_drained", 64'(rd_id_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
